// File: rtl/otbn_insn_prefetch_queue.sv
// Multi-entry OTBN instruction prefetch queue: streams sequential IMEM reads into a FIFO,
// follows hardware loops and halts after branches. Optional macro: OTBN_PREFETCH_INTG_CHECK_EN.
module otbn_insn_prefetch_queue #(
  parameter int unsigned ImemSizeByte  = 4096,
  parameter int unsigned Depth         = 4,
  parameter int unsigned MaxLoopIter   = 32,
  localparam int unsigned ImemAddrWidth = $clog2(ImemSizeByte)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  output logic                     imem_req_o,
  output logic [ImemAddrWidth-1:0] imem_addr_o,
  input  logic [38:0]              imem_rdata_i,
  input  logic                     imem_rvalid_i,

  input  logic                     prefetch_en_i,

  input  logic                     fetch_req_valid_i,
  input  logic [ImemAddrWidth-1:0] fetch_req_addr_i,
  output logic                     fetch_resp_valid_o,
  output logic [ImemAddrWidth-1:0] fetch_resp_addr_o,
  output logic [31:0]              fetch_resp_data_o,
  output logic                     fetch_intg_err_o,
  output logic                     fetch_miss_o,

  input  logic                     clear_i,

  input  logic                     loop_start_i,
  input  logic                     loop_active_i,
  input  logic [ImemAddrWidth:0]   loop_end_addr_i,
  input  logic [ImemAddrWidth-1:0] loop_jump_addr_i,
  input  logic [MaxLoopIter-1:0]   loop_iterations_i
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW:0]   DepthOcc = (CntW + 1)'(Depth);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  typedef enum logic {StStream, StHalt} state_e;

  function automatic logic is_branch(logic [6:0] opcode);
    return (opcode == 7'h63) || (opcode == 7'h6f) || (opcode == 7'h67);
  endfunction

  logic [ImemAddrWidth-1:0] q_addr_q [Depth];
  logic [38:0]              q_data_q [Depth];

  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]          count_q, count_d;
  logic                     inflight_q, inflight_d;
  logic [ImemAddrWidth-1:0] inflight_addr_q, inflight_addr_d;
  logic [ImemAddrWidth-1:0] next_addr_q, next_addr_d;
  logic [MaxLoopIter-1:0]   wraps_q, wraps_d;
  state_e                   state_q, state_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [ImemAddrWidth-1:0] resp_addr_q, resp_addr_d;
  logic [38:0]              resp_data_q, resp_data_d;

  logic [ImemAddrWidth-1:0] head_addr;
  logic [38:0]              head_data;
  logic                     hit_raw, pending, hit, miss, flush_now;
  logic                     push, push_branch, pop;
  logic [CntW:0]            occ;
  logic                     issue_seq, issue_miss, req;
  logic [ImemAddrWidth-1:0] issue_addr;
  logic [MaxLoopIter-1:0]   wraps_base;
  logic [MaxLoopIter:0]     wraps_inc;
  logic                     loop_wrap;

  always_comb begin
    head_addr = q_addr_q[rd_ptr_q];
    head_data = q_data_q[rd_ptr_q];

    hit_raw = fetch_req_valid_i & (count_q != '0) & (head_addr == fetch_req_addr_i);
    // A request whose word is already on its way (typically the redirect read issued by the
    // previous miss) must wait for it instead of redirecting again.
    pending = (count_q == '0) & inflight_q & (inflight_addr_q == fetch_req_addr_i);
    hit       = hit_raw & ~clear_i;
    miss      = fetch_req_valid_i & ~hit_raw & ~pending & ~clear_i;
    flush_now = clear_i | miss;

    push        = imem_rvalid_i & inflight_q & ~flush_now;
    push_branch = push & is_branch(imem_rdata_i[6:0]);
    pop         = hit;

    occ        = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    issue_seq  = prefetch_en_i & (state_q == StStream) & ~push_branch & (occ < DepthOcc) &
                 ~flush_now;
    issue_miss = miss & prefetch_en_i;
    req        = ~rst_i & (issue_seq | issue_miss);
    issue_addr = miss ? fetch_req_addr_i : next_addr_q;

    wraps_base = (loop_start_i | clear_i) ? '0 : wraps_q;
    wraps_inc  = {1'b0, wraps_base} + {{MaxLoopIter{1'b0}}, 1'b1};
    loop_wrap  = ({1'b0, issue_addr} == loop_end_addr_i) & loop_active_i &
                 (wraps_inc < {1'b0, loop_iterations_i});

    next_addr_d = next_addr_q;
    wraps_d     = wraps_base;
    if (miss) begin
      next_addr_d = fetch_req_addr_i;
    end
    if (req) begin
      if (loop_wrap) begin
        next_addr_d = loop_jump_addr_i;
        wraps_d     = wraps_inc[MaxLoopIter-1:0];
      end else begin
        next_addr_d = issue_addr + ImemAddrWidth'(4);
      end
    end

    inflight_d      = req;
    inflight_addr_d = issue_addr;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_now) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end

    // A branch is always the youngest entry, so popping it is what releases the halt.
    state_d = state_q;
    if (flush_now) begin
      state_d = StStream;
    end else begin
      if (pop && is_branch(head_data[6:0])) state_d = StStream;
      if (push_branch)                      state_d = StHalt;
    end

    resp_valid_d = resp_valid_q;
    resp_addr_d  = resp_addr_q;
    resp_data_d  = resp_data_q;
    if (clear_i) begin
      resp_valid_d = 1'b0;
    end else if (hit) begin
      resp_valid_d = 1'b1;
      resp_addr_d  = head_addr;
      resp_data_d  = head_data;
    end else if (fetch_req_valid_i) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_addr_q[wr_ptr_q] <= inflight_addr_q;
      q_data_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      next_addr_q     <= '0;
      wraps_q         <= '0;
      state_q         <= StStream;
      resp_valid_q    <= 1'b0;
      resp_addr_q     <= '0;
      resp_data_q     <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      next_addr_q     <= next_addr_d;
      wraps_q         <= wraps_d;
      state_q         <= state_d;
      resp_valid_q    <= resp_valid_d;
      resp_addr_q     <= resp_addr_d;
      resp_data_q     <= resp_data_d;
    end
  end

  assign imem_req_o         = req;
  assign imem_addr_o        = issue_addr;
  assign fetch_miss_o       = miss & ~rst_i;
  assign fetch_resp_valid_o = resp_valid_q;
  assign fetch_resp_addr_o  = resp_addr_q;
  assign fetch_resp_data_o  = resp_data_q[31:0];

`ifdef OTBN_PREFETCH_INTG_CHECK_EN
  logic [1:0]  intg_err;
  logic [31:0] unused_dec_data;
  logic [6:0]  unused_dec_syndrome;

  prim_secded_inv_39_32_dec u_intg_dec (
    .data_i     (resp_data_q),
    .data_o     (unused_dec_data),
    .syndrome_o (unused_dec_syndrome),
    .err_o      (intg_err)
  );

  assign fetch_intg_err_o = (|intg_err) & resp_valid_q;
`else
  logic unused_intg_bits;
  assign unused_intg_bits = ^resp_data_q[38:32];
  assign fetch_intg_err_o = 1'b0;
`endif

  push_never_full_a : assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> (count_q != DepthCnt));

endmodule

// File: doc/otbn_insn_prefetch_queue.md
Name: otbn_insn_prefetch_queue

Overview:
- Multi-entry instruction prefetch queue for the OTBN fetch stage; successor to the single-slot prefetcher.
- Streams sequential IMEM reads into a Depth-entry FIFO of {addr, 39-bit integrity-protected word}.
- Follows hardware loops without bubbles; halts streaming after any branch/jump opcode.
- Serves registered fetch responses to the decode/execute stage.

Parameters:
- ImemSizeByte, 4096, IMEM size; ImemAddrWidth = vbits(ImemSizeByte).
- Depth, 4, queue entries, power of two, 2..16.
- MaxLoopIter, 32, width of the loop iteration count input.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- imem_req_o  out  1  IMEM read request
- imem_addr_o  out  ImemAddrWidth  IMEM byte address
- imem_rdata_i  in  39  IMEM data incl. integrity
- imem_rvalid_i  in  1  read data valid, exactly 1 cycle after imem_req_o
- prefetch_en_i  in  1  allow issuing IMEM reads
- fetch_req_valid_i  in  1  execute stage requests an instruction
- fetch_req_addr_i  in  ImemAddrWidth  requested address
- fetch_resp_valid_o  out  1  response valid
- fetch_resp_addr_o  out  ImemAddrWidth  response address
- fetch_resp_data_o  out  32  instruction, integrity stripped
- fetch_intg_err_o  out  1  integrity error on valid response
- fetch_miss_o  out  1  pulse: request did not match queue head
- clear_i  in  1  flush queue, drop response
- loop_start_i  in  1  pulse: new loop begins, clears wrap counter
- loop_active_i  in  1  loop in progress
- loop_end_addr_i  in  ImemAddrWidth+1  address of last loop body insn
- loop_jump_addr_i  in  ImemAddrWidth  loop body start
- loop_iterations_i  in  MaxLoopIter  total iterations of current loop

Behaviour:
- Reset (rst_i sampled high at clk edge): queue empty, next_addr=0, inflight=0, wraps=0, state STREAM.
- Reset outputs: fetch_resp_valid_o=0, fetch_resp_addr_o=0, fetch_resp_data_o=0, fetch_intg_err_o=0, fetch_miss_o=0, imem_req_o=0.
- Reset mid-operation: all state dropped; rdata returning the cycle after reset is ignored.
- Issue rule:
  - imem_req_o = prefetch_en_i & state==STREAM & (count + inflight < Depth) & ~flush_now.
  - imem_addr_o = next_addr, or the redirect address in a miss cycle.
- next_addr after an issue:
  - If {1'b0, issued_addr} == loop_end_addr_i and loop_active_i and wraps+1 < loop_iterations_i: next_addr = loop_jump_addr_i, wraps += 1.
  - Otherwise next_addr = issued_addr + 4, wrapping modulo 2^ImemAddrWidth.
  - wraps cleared by loop_start_i, clear_i, or reset.
- Enqueue:
  - imem_rvalid_i pushes {issued_addr, imem_rdata_i}, except in a flush cycle, where the data is dropped.
  - If rdata[6:0] is Branch/Jal/Jalr, state goes to HALT.
- HALT: no issues until the next flush or the next hit that pops the branch entry; then state returns to STREAM with next_addr unchanged unless redirected.
- Hit: fetch_req_valid_i & count>0 & head.addr == fetch_req_addr_i.
  - Pop the head.
  - Next cycle: fetch_resp_valid_o=1, with addr and data registered from the head.
- Miss: fetch_req_valid_i & ~hit.
  - flush_now=1: queue emptied, inflight data dropped.
  - Same cycle: issue request at fetch_req_addr_i; next_addr = req+4; state STREAM.
  - fetch_miss_o=1 for that cycle; fetch_resp_valid_o=0 next cycle.
  - Requester holds the request: miss at cycle 0 gives a hit at cycle 2 and response valid at cycle 3.
- No request: fetch_resp_valid_o holds its value, cleared by clear_i.
- clear_i:
  - Flushes queue, clears response valid next cycle, wraps=0, state STREAM.
  - Does not issue a request that cycle.
  - clear_i together with fetch_req_valid_i: clear wins, no miss pulse.
- Simultaneous push and pop when full: legal, count unchanged.
- Push when count==Depth cannot occur (issue rule); assert it.

Optional Feature:
- Macro OTBN_PREFETCH_INTG_CHECK_EN.
- Defined: prim_secded_inv_39_32_dec on the registered response word; fetch_intg_err_o = |err & fetch_resp_valid_o.
- Undefined: no decoder instantiated; fetch_intg_err_o tied 0; bits [38:32] unused.

Test Plan:
- Reset release, prefetch_en_i=1, no requests -> reads at 0x0, 0x4, 0x8, 0xC; req drops with 4 entries (Depth=4).
- Full queue, then requests 0x0 and 0x4 on consecutive cycles -> responses valid in the following cycles, addr 0x0 then 0x4; new reads at 0x10, 0x14.
- IMEM word at 0x8 is JAL -> no read after 0x8 until the 0x8 hit; request 0x40 -> miss pulse, read at 0x40 the same cycle, response valid 3 cycles after the first request.
- loop_start_i, jump 0x20, end 0x28, iterations 3 -> issued sequence 0x20, 24, 28, 20, 24, 28, 20, 24, 28, 2C.
- clear_i asserted with a read in flight -> returning data dropped, queue empty, fetch_resp_valid_o=0 next cycle.
- (Feature on) flip one bit of rdata at 0x4 -> fetch_intg_err_o=1 on the 0x4 response only; double flip also gives 1.
